// File: rtl/instruction_decode_queue.sv
// instruction_decode_queue: DEPTH-entry FIFO of instruction words with first-word fall-through field decode.
module instruction_decode_queue #(
    parameter int DEPTH      = 4,
    parameter int REG_ADDR_W = 3,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           INSTRUCTION,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  FLUSH,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [7:0]            OPCODE,
    output logic [7:0]            OFFSET,
    output logic [REG_ADDR_W-1:0] WRITEREG,
    output logic [REG_ADDR_W-1:0] READREG1,
    output logic [REG_ADDR_W-1:0] READREG2,
    output logic [7:0]            IMMEDIATE,
    output logic [CW-1:0]         COUNT
);
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [31:0]   head;
    logic          push, pop;

    assign IN_READY  = COUNT != CW'(DEPTH);
    assign OUT_VALID = COUNT != '0;
    assign push      = IN_VALID && IN_READY && !FLUSH && !RESET;
    assign pop       = OUT_VALID && OUT_READY && !FLUSH && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            wp    <= '0;
            rp    <= '0;
            COUNT <= '0;
        end else begin
            wp    <= push ? wp + 1'b1 : wp;
            rp    <= pop ? rp + 1'b1 : rp;
            COUNT <= COUNT + CW'(push) - CW'(pop);
        end
    end

    // Storage is deliberately left unreset; OUT_VALID masks stale entries.
    always_ff @(posedge CLK) begin
        if (push) mem[wp] <= INSTRUCTION;
    end

    assign head      = OUT_VALID ? mem[rp] : '0;
    assign OPCODE    = head[31:24];
    assign OFFSET    = head[23:16];
    assign WRITEREG  = head[16 +: REG_ADDR_W];
    assign READREG1  = head[8 +: REG_ADDR_W];
    assign READREG2  = head[0 +: REG_ADDR_W];
    assign IMMEDIATE = head[7:0];
endmodule
